// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Optional build macro: LSU_MISALIGN_CHECK_EN (see lsu_align.sv).
package lsu_pkg;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    RESP
  } lsu_state_e;

  // RISC-V funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Base byte-enable patterns before shifting to the addressed lane
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Stores only know B/H/W; loads additionally have the unsigned forms
  function automatic logic lsu_type_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store data
// replication, load lane extraction and sign/zero extension.
// Build macro LSU_MISALIGN_CHECK_EN: when defined, misaligned halfword/word
// accesses are reported as errors; otherwise offending low address bits are
// forced to zero and the access proceeds.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_type_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic        st_err_o,
  output logic [1:0]  st_off_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_rdata_o
);

  logic        st_legal;
  logic [31:0] ld_shift;

  assign st_legal = lsu_type_legal(st_we_i, st_type_i);

  // Snap the lane offset down to the natural alignment of the access size
  always_comb begin
    st_off_o = st_off_i;
    case (st_type_i[1:0])
      2'b01:   st_off_o = {st_off_i[1], 1'b0};
      2'b10:   st_off_o = 2'b00;
      default: st_off_o = st_off_i;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic misaligned;

  // Flag halfword/word accesses whose offset breaks natural alignment
  always_comb begin
    misaligned = 1'b0;
    case (st_type_i[1:0])
      2'b01:   misaligned = st_off_i[0];
      2'b10:   misaligned = |st_off_i;
      default: misaligned = 1'b0;
    endcase
  end

  assign st_err_o = ~st_legal | misaligned;
`else
  assign st_err_o = ~st_legal;
`endif

  // Byte enables and lane-replicated write data for the aligned offset
  always_comb begin
    st_be_o    = BE_NONE;
    st_wdata_o = st_wdata_i;
    case (st_type_i[1:0])
      2'b00: begin
        st_be_o    = BE_B << st_off_o;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = BE_H << st_off_o;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      2'b10: begin
        st_be_o    = BE_W;
        st_wdata_o = st_wdata_i;
      end
      default: begin
        st_be_o    = BE_NONE;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};

  // Pick the addressed lane out of the bus word and extend it to 32 bits
  always_comb begin
    ld_rdata_o = '0;
    case (ld_type_i)
      F3_B:    ld_rdata_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_rdata_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_W:    ld_rdata_o = ld_shift;
      F3_BU:   ld_rdata_o = {24'b0, ld_shift[7:0]};
      F3_HU:   ld_rdata_o = {16'b0, ld_shift[15:0]};
      default: ld_rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding req/gnt/rvalid data-memory transaction
// per execute-stage request, with registered handshake outputs.
// Build macro LSU_MISALIGN_CHECK_EN enables misalignment errors.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_type_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              lsu_rvalid_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              busy_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic              rvalid_q, rvalid_d;
  logic              err_out_q, err_out_d;

  logic              st_err;
  logic [1:0]        st_off;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_rdata;

  lsu_align u_align (
    .st_we_i    (lsu_we_i),
    .st_type_i  (lsu_type_i),
    .st_off_i   (lsu_addr_i[1:0]),
    .st_wdata_i (lsu_wdata_i),
    .st_err_o   (st_err),
    .st_off_o   (st_off),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_type_i  (type_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (data_rdata_i),
    .ld_rdata_o (ld_rdata)
  );

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          we_d    = lsu_we_i;
          type_d  = lsu_type_i;
          off_d   = st_off;
          addr_d  = lsu_addr_i & ADDR_ALIGN_MASK;
          be_d    = st_be;
          wdata_d = st_wdata;
          rdata_d = '0;
          err_d   = st_err;
          state_d = st_err ? RESP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          rdata_d = we_q ? 32'h0 : ld_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d   = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    req_d     = (state_d == WAIT_GNT);
    rvalid_d  = (state_d == RESP);
    err_out_d = (state_d == RESP) & err_d;
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      type_q    <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      type_q    <= type_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      req_q     <= req_d;
      rvalid_q  <= rvalid_d;
      err_out_q <= err_out_d;
    end
  end

  assign lsu_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign lsu_rvalid_o = rvalid_q;
  assign lsu_err_o    = err_out_q;
  assign lsu_rdata_o  = rdata_q;
  assign data_req_o   = req_q;
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: randomized load/store traffic against a behavioural
// model, plus directed cases with hand-computed literal expectations.
module tb_lsu;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_type_i = '0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_ready_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        busy_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit checking = 0;
  bit exp_ready = 1;
  bit exp_bus = 0;
  bit exp_rvalid = 0;
  exp_t cur;
  exp_t resp_q[$];
  int accept_cyc = 0;
  int req_cycles = 0;
  int last_rv_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic [31:0] last_addr = '0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wdata = '0;
  logic        last_we = 1'b0;

  lsu dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lsu_req_i     (lsu_req_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_type_i    (lsu_type_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .lsu_rdata_o   (lsu_rdata_o),
    .lsu_err_o     (lsu_err_o),
    .busy_o        (busy_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected result of one operation, from access size, lane and extension rules
  function automatic exp_t model_op(input logic we, input logic [2:0] t, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int size;
    int lane;
    bit legal;
    bit mis;
    logic [31:0] v;
    logic [31:0] mask;
    e = '0;
    size = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : (t[1:0] == 2'd2) ? 4 : 1;
    if (we) legal = (t == 3'd0) || (t == 3'd1) || (t == 3'd2);
    else    legal = (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd4) || (t == 3'd5);
    lane = int'(a % 4);
    mis = (lane % size) != 0;
`ifdef LSU_MISALIGN_CHECK_EN
    e.err = !legal || mis;
`else
    e.err = !legal;
    lane = lane - (lane % size);
`endif
    e.we = we;
    e.addr = a & 32'hFFFF_FFFC;
    e.be = 4'(((1 << size) - 1) << lane);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(wd >> (8 * (i % size)));
    if (we || e.err) begin
      e.rdata = 32'h0;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (rd >> (8 * lane)) & mask;
      if (!t[2] && size < 4 && v >= (32'd1 << (8 * size - 1))) v = v - (32'd1 << (8 * size));
      e.rdata = v;
    end
    return e;
  endfunction

  // Per-cycle comparison of DUT outputs against the model's expectations
  always @(negedge clk_i) begin
    if (checking) begin
      exp_t r;
      check_output("ready", 32'(lsu_ready_o), 32'(exp_ready));
      check_output("busy", 32'(busy_o), 32'(!exp_ready));
      check_output("data_req", 32'(data_req_o), 32'(exp_bus));
      check_output("lsu_rvalid", 32'(lsu_rvalid_o), 32'(exp_rvalid));
      if (data_req_o) begin
        req_cycles++;
        last_addr = data_addr_o;
        last_be = data_be_o;
        last_wdata = data_wdata_o;
        last_we = data_we_o;
      end
      if (exp_bus) begin
        check_output("bus_addr", data_addr_o, cur.addr);
        check_output("bus_be", 32'(data_be_o), 32'(cur.be));
        check_output("bus_we", 32'(data_we_o), 32'(cur.we));
        if (cur.we) check_output("bus_wdata", data_wdata_o, cur.wdata);
      end
      if (lsu_rvalid_o && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        last_rdata = lsu_rdata_o;
        last_err = lsu_err_o;
        last_rv_cyc = cyc;
        check_output("resp_rdata", lsu_rdata_o, r.rdata);
        check_output("resp_err", 32'(lsu_err_o), 32'(r.err));
      end else begin
        check_output("err_idle", 32'(lsu_err_o), 32'd0);
      end
    end
  end

  // One full operation: request, bus handshake with chosen delays, response
  task automatic apply_stimulus(input logic we, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int gnt_dly, input int rv_dly, input bit spurious);
    exp_t e;
    e = model_op(we, t, a, wd, rd);
    cur = e;
    resp_q.push_back(e);
    lsu_req_i = 1'b1;
    lsu_we_i = we;
    lsu_type_i = t;
    lsu_addr_i = a;
    lsu_wdata_i = wd;
    accept_cyc = cyc;
    req_cycles = 0;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    lsu_we_i = 1'($urandom);
    lsu_type_i = 3'($urandom);
    lsu_addr_i = $urandom;
    lsu_wdata_i = $urandom;
    exp_ready = 0;
    if (e.err) begin
      exp_rvalid = 1;
      @(posedge clk_i); #1;
      exp_rvalid = 0;
      exp_ready = 1;
    end else begin
      exp_bus = 1;
      for (int i = 0; i < gnt_dly; i++) begin
        data_rvalid_i = spurious & 1'($urandom);
        data_rdata_i = $urandom;
        @(posedge clk_i); #1;
      end
      data_rvalid_i = 1'b0;
      data_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      data_gnt_i = 1'b0;
      exp_bus = 0;
      for (int i = 0; i < rv_dly; i++) begin
        @(posedge clk_i); #1;
      end
      data_rvalid_i = 1'b1;
      data_rdata_i = rd;
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;
      data_rdata_i = $urandom;
      exp_rvalid = 1;
      @(posedge clk_i); #1;
      exp_rvalid = 0;
      exp_ready = 1;
    end
    check_output("resp_drained", 32'(resp_q.size()), 32'd0);
    resp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("rst_ready", 32'(lsu_ready_o), 32'd1);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_req", 32'(data_req_o), 32'd0);
    check_output("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
    check_output("rst_err", 32'(lsu_err_o), 32'd0);
    check_output("rst_rdata", lsu_rdata_o, 32'd0);
    check_output("rst_addr", data_addr_o, 32'd0);
    check_output("rst_be", 32'(data_be_o), 32'd0);
    rst_ni = 1'b1;
    checking = 1;

    // LW minimum latency
    apply_stimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    check_output("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    check_output("lw_be", 32'(last_be), 32'hF);
    check_output("lw_latency", 32'(last_rv_cyc - accept_cyc), 32'd3);

    // LB / LBU sign vs zero extension
    apply_stimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h8000_0000, 0, 0, 0);
    check_output("lb_rdata", last_rdata, 32'hFFFF_FF80);
    apply_stimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h8000_0000, 1, 1, 0);
    check_output("lbu_rdata", last_rdata, 32'h0000_0080);

    // SH lane replication
    apply_stimulus(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 0, 2, 0);
    check_output("sh_addr", last_addr, 32'h200);
    check_output("sh_be", 32'(last_be), 32'hC);
    check_output("sh_wdata", last_wdata, 32'hABCD_ABCD);
    check_output("sh_we", 32'(last_we), 32'd1);
    check_output("sh_rdata", last_rdata, 32'd0);

    // Grant withheld for five cycles, with stray rvalids in the meantime
    apply_stimulus(1'b0, 3'b010, 32'h340, 32'h0, 32'h0BAD_F00D, 5, 0, 1);
    check_output("stall_req_cycles", 32'(req_cycles), 32'd6);

    // Misaligned word load
    apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check_output("lw_mis_err", 32'(last_err), 32'd1);
    check_output("lw_mis_noreq", 32'(req_cycles), 32'd0);
`else
    check_output("lw_mis_addr", last_addr, 32'h100);
    check_output("lw_mis_be", 32'(last_be), 32'hF);
    check_output("lw_mis_rdata", last_rdata, 32'h1122_3344);
`endif

    // Illegal load type
    apply_stimulus(1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0, 0, 0);
    check_output("illegal_err", 32'(last_err), 32'd1);
    check_output("illegal_noreq", 32'(req_cycles), 32'd0);

    // Reset while waiting for rvalid, then a late rvalid
    cur = model_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
    lsu_req_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_type_i = 3'b010;
    lsu_addr_i = 32'h300;
    @(posedge clk_i); #1;
    lsu_req_i = 1'b0;
    exp_ready = 0;
    exp_bus = 1;
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    exp_bus = 0;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    exp_ready = 1;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    check_output("rst_mid_ready", 32'(lsu_ready_o), 32'd1);
    check_output("rst_mid_rvalid", 32'(lsu_rvalid_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
